// File: rtl/btn_step_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_step_gen_if : button input / step output bundle                 |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
interface btn_step_gen_if;
  logic       btn;
  logic       pressed;
  logic       step;
  logic [7:0] press_count;

  modport master (output btn, input pressed, input step, input press_count);
  modport slave  (input btn, output pressed, output step, output press_count);
endinterface
`default_nettype wire

// File: rtl/btn_step_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_step_gen : sync + debounce a push-button into one-cycle steps   |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module btn_step_gen #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  btn_step_gen_if.slave bus
);

  // Repeat intervals below 2 would put two steps in adjacent cycles.
  localparam int c_delay_eff  = (REPEAT_DELAY  < 2) ? 2 : REPEAT_DELAY;
  localparam int c_period_eff = (REPEAT_PERIOD < 2) ? 2 : REPEAT_PERIOD;
  localparam int c_rpt_max    = (c_delay_eff > c_period_eff) ? c_delay_eff : c_period_eff;
  localparam int c_db_w       = $clog2(DEBOUNCE_CYCLES);
  localparam int c_rpt_w      = $clog2(c_rpt_max);
  localparam bit c_rpt_on     = (REPEAT_EN != 0);

  localparam logic [c_db_w-1:0]  c_db_last     = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_rpt_w-1:0] c_delay_last  = c_rpt_w'(c_delay_eff - 1);
  localparam logic [c_rpt_w-1:0] c_period_last = c_rpt_w'(c_period_eff - 1);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_held   = 2'd1;
  localparam logic [1:0] c_st_repeat = 2'd2;

  logic [1:0]         r_sync;
  logic [c_db_w-1:0]  r_db_cnt;
  logic               r_pressed;
  logic [1:0]         r_state;
  logic [c_rpt_w-1:0] r_rpt_cnt;
  logic               r_step;
  logic [7:0]         r_press_count;

  logic w_btn_s;
  logic w_diff;
  logic w_accept;

  assign w_btn_s  = r_sync[1];
  assign w_diff   = w_btn_s ^ r_pressed;
  assign w_accept = w_diff && (r_db_cnt == c_db_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], bus.btn};
    end
  end

  // Any sample matching the accepted level restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt  <= '0;
      r_pressed <= 1'b0;
    end else if (!w_diff) begin
      r_db_cnt <= '0;
    end else if (w_accept) begin
      r_db_cnt  <= '0;
      r_pressed <= ~r_pressed;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_st_idle;
      r_rpt_cnt <= '0;
      r_step    <= 1'b0;
    end else begin
      r_step <= 1'b0;
      case (r_state)
        c_st_idle: begin
          r_rpt_cnt <= '0;
          if (w_accept) begin
            r_step  <= 1'b1;
            r_state <= c_st_held;
          end
        end
        c_st_held: begin
          // A release wins over a repeat falling due in the same cycle.
          if (w_accept) begin
            r_rpt_cnt <= '0;
            r_state   <= c_st_idle;
          end else if (c_rpt_on && (r_rpt_cnt == c_delay_last)) begin
            r_step    <= 1'b1;
            r_rpt_cnt <= '0;
            r_state   <= c_st_repeat;
          end else if (c_rpt_on) begin
            r_rpt_cnt <= r_rpt_cnt + 1'b1;
          end
        end
        c_st_repeat: begin
          if (w_accept) begin
            r_rpt_cnt <= '0;
            r_state   <= c_st_idle;
          end else if (r_rpt_cnt == c_period_last) begin
            r_step    <= 1'b1;
            r_rpt_cnt <= '0;
          end else begin
            r_rpt_cnt <= r_rpt_cnt + 1'b1;
          end
        end
        default: begin
          r_rpt_cnt <= '0;
          r_state   <= c_st_idle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_press_count <= 8'd0;
    end else if (r_step) begin
      r_press_count <= r_press_count + 8'd1;
    end
  end

  assign bus.pressed     = r_pressed;
  assign bus.step        = r_step;
  assign bus.press_count = r_press_count;

endmodule
`default_nettype wire
